mip_dispatch_ctrl: RTL and testbench
====================================

MIP_DISPATCH_CTRL -- requirements
Module: mip_dispatch_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 128: width of one FIFO entry and of the worker data bus.
REQ-002 Parameter NUM_WORKERS, default 4, legal range 2..16: number of downstream workers.
REQ-003 Parameter WID_W, default $clog2(NUM_WORKERS): width of the worker index.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 srst_n  input  1  reset, synchronous and active-low.
REQ-006 enable  input  1  level; 1 allows new fetches from the FIFO.
REQ-007 fifo_empty  input  1  FIFO empty flag.
REQ-008 fifo_rd_en  output  1  FIFO read strobe; FIFO returns data on fifo_rd_data in the cycle after the strobe.
REQ-009 fifo_rd_data  input  DATA_WIDTH  registered FIFO read data.
REQ-010 w_ready  input  NUM_WORKERS  per-worker accept.
REQ-011 w_valid  output  NUM_WORKERS  per-worker offer; at most one bit set.
REQ-012 w_data  output  DATA_WIDTH  entry data, shared by all workers.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 dispatch_cnt  output  32  count of completed worker handshakes.
REQ-015 stall_cnt  output  32  count of SEND-state cycles in which the target's w_ready is 0.

Function
REQ-016 The FSM SHALL have four states: IDLE, FETCH, LATCH and SEND.
REQ-017 IDLE SHALL go to FETCH when enable=1 and fifo_empty=0, and SHALL otherwise stay in IDLE.
REQ-018 FETCH SHALL assert fifo_rd_en=1 for exactly that one cycle and go to LATCH.
REQ-019 fifo_rd_en SHALL be 0 in all states other than FETCH.
REQ-020 In LATCH, the block SHALL capture fifo_rd_data into a hold register driving w_data, and SHALL choose the target worker.
REQ-021 Target rule: the first index i, searching upward from rr_ptr with modulo-NUM_WORKERS wrap, with w_ready[i]=1 in the LATCH cycle; if no worker is ready, target = rr_ptr.
REQ-022 LATCH SHALL go unconditionally to SEND.
REQ-023 In SEND, w_valid[target] SHALL be 1, all other w_valid bits SHALL be 0, and w_data SHALL hold stable.
REQ-024 The target SHALL NOT change while in SEND, even if other workers become ready.
REQ-025 SEND handshake (w_ready[target]=1) SHALL: increment dispatch_cnt, set rr_ptr = target+1 (wrapping NUM_WORKERS-1 to 0), and go to FETCH if enable=1 and fifo_empty=0, else to IDLE.
REQ-026 Back-to-back operation SHALL be 3 cycles per entry: SEND, FETCH, LATCH.
REQ-027 Deasserting enable SHALL NOT abort an entry in FETCH, LATCH or SEND; that entry SHALL complete, and the FSM then returns to IDLE.
REQ-028 Each SEND cycle without a handshake SHALL increment stall_cnt.
REQ-029 dispatch_cnt and stall_cnt SHALL wrap from 0xFFFFFFFF to 0.
REQ-030 w_valid SHALL be all-zero in IDLE, FETCH and LATCH.
REQ-031 fifo_empty SHALL be sampled only in IDLE and at the SEND handshake; no read is issued while fifo_empty=1.
REQ-032 The block SHALL never issue a second fifo_rd_en before the held entry has been handshaked, so exactly one entry is in flight.

Reset
REQ-033 While srst_n=0 at a rising edge, the block SHALL set: state=IDLE, rr_ptr=0, hold register=0, dispatch_cnt=0, stall_cnt=0.
REQ-034 During and after that reset edge, outputs SHALL be: fifo_rd_en=0, w_valid=0, w_data=0, busy=0.
REQ-035 Reset asserted in any state, including mid-SEND, SHALL drop the held entry without a handshake and without counting it.
REQ-036 On the first cycle after srst_n returns to 1, the block SHALL follow the IDLE rules.

Verification
REQ-037 FIFO holds A,B,C; all w_ready=1; enable=1 -> A to worker 0, B to worker 1, C to worker 2; fifo_rd_en pulses 3 cycles apart; dispatch_cnt=3; busy falls after C.
REQ-038 One entry; rr_ptr=0; w_ready=4'b0100 during LATCH -> w_valid=4'b0100; afterwards rr_ptr=3.
REQ-039 One entry; w_ready=0 for 5 SEND cycles, then w_ready[0]=1 -> w_valid[0] held 6 cycles, w_data stable, stall_cnt=5, dispatch_cnt=1.
REQ-040 enable dropped during LATCH with 2 entries queued -> the current entry completes; no further fifo_rd_en; FSM in IDLE; busy=0.
REQ-041 srst_n=0 for 1 cycle during SEND -> w_valid=0 the next cycle; counters=0; rr_ptr=0; the next entry goes to worker 0.
REQ-042 NUM_WORKERS=4, 5 entries, all ready -> targets 0,1,2,3,0 (wrap).

Source files
------------

// File: rtl/mip_dispatch_ctrl.sv
// Single-entry dispatcher: fetches one FIFO entry at a time, holds it, and offers it
// to one worker chosen round-robin among those ready when the entry is latched.
module mip_dispatch_ctrl #(
    parameter int DATA_WIDTH  = 128,
    parameter int NUM_WORKERS = 4,
    parameter int WID_W       = $clog2(NUM_WORKERS)
) (
    input  logic                   clk,
    input  logic                   srst_n,
    input  logic                   enable,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic [NUM_WORKERS-1:0] w_ready,
    output logic [NUM_WORKERS-1:0] w_valid,
    output logic [DATA_WIDTH-1:0]  w_data,
    output logic                   busy,
    output logic [31:0]            dispatch_cnt,
    output logic [31:0]            stall_cnt
);

    typedef enum logic [1:0] {IDLE, FETCH, LATCH, SEND} state_e;

    localparam logic [WID_W:0]   NW_EXT   = (WID_W+1)'(NUM_WORKERS);
    localparam logic [WID_W-1:0] LAST_IDX = WID_W'(NUM_WORKERS - 1);

    state_e                 state_q;
    logic [WID_W-1:0]       rr_ptr_q;
    logic [WID_W-1:0]       target_q;
    logic [DATA_WIDTH-1:0]  hold_q;
    logic                   rd_en_q;
    logic                   busy_q;
    logic [NUM_WORKERS-1:0] valid_q;
    logic [31:0]            disp_q;
    logic [31:0]            stall_q;

    logic [WID_W-1:0]       pick_d;
    logic [NUM_WORKERS-1:0] pick_onehot_d;
    logic [WID_W-1:0]       next_rr_d;
    logic                   start_d;

    // Walk downward so the lowest offset from rr_ptr_q that is ready wins last.
    always_comb begin
        logic [WID_W:0] sum;
        sum    = '0;
        pick_d = rr_ptr_q;
        for (int k = NUM_WORKERS - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_q} + (WID_W+1)'(k);
            if (sum >= NW_EXT) begin
                sum = sum - NW_EXT;
            end
            if (w_ready[sum[WID_W-1:0]]) begin
                pick_d = sum[WID_W-1:0];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORKERS; gi++) begin : g_onehot
            assign pick_onehot_d[gi] = (pick_d == WID_W'(gi));
        end
    endgenerate

    assign next_rr_d = (target_q == LAST_IDX) ? '0 : target_q + WID_W'(1);
    assign start_d   = enable && !fifo_empty;

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            target_q <= '0;
            hold_q   <= '0;
            rd_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= '0;
            disp_q   <= '0;
            stall_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_d) begin
                        state_q <= FETCH;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                FETCH: begin
                    state_q <= LATCH;
                    rd_en_q <= 1'b0;
                end
                LATCH: begin
                    hold_q   <= fifo_rd_data;
                    target_q <= pick_d;
                    valid_q  <= pick_onehot_d;
                    state_q  <= SEND;
                end
                SEND: begin
                    if (w_ready[target_q]) begin
                        disp_q   <= disp_q + 32'd1;
                        rr_ptr_q <= next_rr_d;
                        valid_q  <= '0;
                        if (start_d) begin
                            state_q <= FETCH;
                            rd_en_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        stall_q <= stall_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rd_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    valid_q <= '0;
                end
            endcase
        end
    end

    assign fifo_rd_en   = rd_en_q;
    assign w_valid      = valid_q;
    assign w_data       = hold_q;
    assign busy         = busy_q;
    assign dispatch_cnt = disp_q;
    assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_mip_dispatch_ctrl.sv
// Bench for mip_dispatch_ctrl: FIFO model, per-cycle transaction-level reference model,
// and directed scenarios with hand-computed targets and counts.
module tb_mip_dispatch_ctrl;

    localparam int DW = 128;
    localparam int NW = 4;

    logic           clk = 1'b0;
    logic           srst_n = 1'b0;
    logic           enable = 1'b0;
    logic           fifo_empty;
    logic           fifo_rd_en;
    logic [DW-1:0]  fifo_rd_data = '0;
    logic [NW-1:0]  w_ready = '0;
    logic [NW-1:0]  w_valid;
    logic [DW-1:0]  w_data;
    logic           busy;
    logic [31:0]    dispatch_cnt;
    logic [31:0]    stall_cnt;

    always #5 clk = ~clk;

    mip_dispatch_ctrl #(.DATA_WIDTH(DW), .NUM_WORKERS(NW)) dut (
        .clk(clk), .srst_n(srst_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .w_ready(w_ready),
        .w_valid(w_valid), .w_data(w_data), .busy(busy),
        .dispatch_cnt(dispatch_cnt), .stall_cnt(stall_cnt)
    );

    // FIFO with registered read data, one cycle after the strobe
    logic [DW-1:0] fifo_mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= fifo_mem[rd_ptr % 64];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one entry in flight, phases fetch -> latch -> offer
    bit            m_fetch = 0;
    bit            m_latch = 0;
    bit            m_offer = 0;
    int            m_tgt = 0;
    int            m_rr = 0;
    logic [31:0]   m_disp = 0;
    logic [31:0]   m_stall = 0;
    logic [DW-1:0] m_data = '0;
    int            cyc = 0;
    int            hs_tgt [$];
    int            rd_cycle [$];

    always @(negedge clk) begin
        logic [NW-1:0] exp_valid;
        bit found;
        int idx;
        cyc++;
        exp_valid = '0;
        if (m_offer) exp_valid[m_tgt] = 1'b1;
        chk("w_valid", w_valid, exp_valid);
        chk("fifo_rd_en", fifo_rd_en, m_fetch);
        chk("busy", busy, m_fetch | m_latch | m_offer);
        chk("dispatch_cnt", dispatch_cnt, m_disp);
        chk("stall_cnt", stall_cnt, m_stall);
        if (m_offer) chk("w_data", w_data, m_data);

        if (fifo_rd_en) rd_cycle.push_back(cyc);
        if (srst_n && ((w_valid & w_ready) != '0)) begin
            idx = -1;
            for (int i = 0; i < NW; i++) if (w_valid[i] && w_ready[i]) idx = i;
            hs_tgt.push_back(idx);
            $display("cycle %0d: entry handed to worker %0d data %0h", cyc, idx, w_data);
        end

        if (!srst_n) begin
            m_fetch = 0; m_latch = 0; m_offer = 0;
            m_tgt = 0; m_rr = 0; m_disp = 0; m_stall = 0;
        end else if (m_fetch) begin
            m_fetch = 0;
            m_latch = 1;
        end else if (m_latch) begin
            found = 0;
            m_tgt = m_rr;
            for (int k = 0; k < NW; k++) begin
                if (!found && w_ready[(m_rr + k) % NW]) begin
                    m_tgt = (m_rr + k) % NW;
                    found = 1;
                end
            end
            m_data  = fifo_mem[(rd_ptr - 1) % 64];
            m_latch = 0;
            m_offer = 1;
        end else if (m_offer) begin
            if (w_ready[m_tgt]) begin
                m_disp++;
                m_rr    = (m_tgt + 1) % NW;
                m_offer = 0;
                m_fetch = enable && !fifo_empty;
            end else begin
                m_stall++;
            end
        end else begin
            m_fetch = enable && !fifo_empty;
        end
    end

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr % 64] = {32'h5A00_0000 + 32'(wr_ptr), 32'h0BAD_0000 ^ 32'(wr_ptr * 7),
                                     32'(wr_ptr) * 32'h0101_0101, ~32'(wr_ptr)};
            wr_ptr++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        enable = 1'b0;
        srst_n = 1'b0;
        @(posedge clk); #1;
        srst_n = 1'b1;
    endtask

    task automatic wait_idle(input string name, input bit need_empty);
        bit ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy && (!need_empty || fifo_empty)) begin
                ok = 1;
                break;
            end
        end
        chk(name, ok, 1'b1);
    endtask

    task automatic wait_valid(input string name);
        bit ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (w_valid != '0) begin
                ok = 1;
                break;
            end
        end
        chk(name, ok, 1'b1);
    endtask

    task automatic wait_rd(input string name);
        bit ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                ok = 1;
                break;
            end
        end
        chk(name, ok, 1'b1);
    endtask

    task automatic chk_targets(input string name, input int base, input int n, input int exp [5]);
        chk({name, " count"}, hs_tgt.size() - base, n);
        if (hs_tgt.size() - base == n) begin
            for (int i = 0; i < n; i++) chk(name, hs_tgt[base + i], exp[i]);
        end
    endtask

    initial begin
        int base, rbase;
        int exp_t [5];

        repeat (2) @(posedge clk);
        #1 srst_n = 1'b1;
        @(negedge clk);
        chk("reset fifo_rd_en", fifo_rd_en, 1'b0);
        chk("reset w_valid", w_valid, 4'b0000);
        chk("reset w_data", w_data, 128'h0);
        chk("reset busy", busy, 1'b0);
        chk("reset dispatch_cnt", dispatch_cnt, 32'd0);
        chk("reset stall_cnt", stall_cnt, 32'd0);

        // Three entries, all ready: workers 0,1,2, strobes 3 cycles apart
        base = hs_tgt.size(); rbase = rd_cycle.size();
        @(posedge clk); #1;
        w_ready = 4'b1111; push(3); enable = 1'b1;
        wait_idle("abc idle", 1);
        exp_t = '{0, 1, 2, 0, 0};
        chk_targets("abc target", base, 3, exp_t);
        chk("abc rd count", rd_cycle.size() - rbase, 3);
        if (rd_cycle.size() - rbase == 3) begin
            chk("abc rd spacing 1", rd_cycle[rbase + 1] - rd_cycle[rbase], 3);
            chk("abc rd spacing 2", rd_cycle[rbase + 2] - rd_cycle[rbase + 1], 3);
        end
        chk("abc dispatch_cnt", dispatch_cnt, 32'd3);
        chk("abc busy", busy, 1'b0);

        // Only worker 2 ready at latch, then rr_ptr must sit at 3
        do_reset();
        base = hs_tgt.size();
        w_ready = 4'b0100; push(1); enable = 1'b1;
        wait_idle("rr idle 1", 1);
        @(posedge clk); #1;
        w_ready = 4'b1111; push(1);
        wait_idle("rr idle 2", 1);
        exp_t = '{2, 3, 0, 0, 0};
        chk_targets("rr target", base, 2, exp_t);

        // Five stall cycles then worker 0 accepts
        do_reset();
        base = hs_tgt.size();
        w_ready = 4'b0000; push(1); enable = 1'b1;
        wait_valid("stall offer");
        chk("stall w_valid", w_valid, 4'b0001);
        repeat (5) @(posedge clk);
        #1 w_ready = 4'b0001;
        @(posedge clk); #1 w_ready = 4'b0000;
        wait_idle("stall idle", 1);
        chk("stall stall_cnt", stall_cnt, 32'd5);
        chk("stall dispatch_cnt", dispatch_cnt, 32'd1);
        exp_t = '{0, 0, 0, 0, 0};
        chk_targets("stall target", base, 1, exp_t);

        // enable dropped during LATCH: current entry finishes, no more reads
        do_reset();
        rbase = rd_cycle.size();
        w_ready = 4'b1111; push(3); enable = 1'b1;
        wait_rd("drop fetch");
        @(posedge clk); #1 enable = 1'b0;
        wait_idle("drop idle", 0);
        repeat (5) @(negedge clk);
        chk("drop rd count", rd_cycle.size() - rbase, 1);
        chk("drop dispatch_cnt", dispatch_cnt, 32'd1);
        chk("drop busy", busy, 1'b0);
        chk("drop fifo_empty", fifo_empty, 1'b0);
        @(posedge clk); #1 enable = 1'b1;
        wait_idle("drop drain", 1);
        chk("drop drain dispatch_cnt", dispatch_cnt, 32'd3);

        // Reset mid-SEND drops the entry; next entry goes to worker 0
        do_reset();
        base = hs_tgt.size();
        w_ready = 4'b1111; push(1); enable = 1'b1;
        wait_idle("rst first", 1);
        @(posedge clk); #1;
        w_ready = 4'b0000; push(1);
        wait_valid("rst offer");
        chk("rst w_valid before", w_valid, 4'b0010);
        @(posedge clk); #1 srst_n = 1'b0;
        @(posedge clk); #1 srst_n = 1'b1;
        @(negedge clk);
        chk("rst w_valid after", w_valid, 4'b0000);
        chk("rst dispatch_cnt", dispatch_cnt, 32'd0);
        chk("rst stall_cnt", stall_cnt, 32'd0);
        chk("rst busy", busy, 1'b0);
        @(posedge clk); #1;
        w_ready = 4'b1111; push(1);
        wait_idle("rst next", 1);
        exp_t = '{0, 0, 0, 0, 0};
        chk_targets("rst target", base, 2, exp_t);

        // Five entries wrap the round-robin pointer
        do_reset();
        base = hs_tgt.size();
        w_ready = 4'b1111; push(5); enable = 1'b1;
        wait_idle("wrap idle", 1);
        exp_t = '{0, 1, 2, 3, 0};
        chk_targets("wrap target", base, 5, exp_t);
        chk("wrap dispatch_cnt", dispatch_cnt, 32'd5);

        @(posedge clk); #1 enable = 1'b0;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
